seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Cycles through digits 0..3, one slot of DIV clocks each, keeps the digit dark
// for the first BLANK clocks of every slot and applies optional leading-zero
// blanking. New display data is staged and promoted only at the frame boundary,
// so a frame never shows a mix of old and new nibbles.
module seven_seg_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic        lzb,
    output logic [3:0]  bcd,
    output logic [3:0]  digit,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int                 CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W:0]     BLANK_V = (CNT_W + 1)'(BLANK);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      act_val_q, act_val_d;
    logic [3:0]       act_dp_q, act_dp_d;
    logic [15:0]      stg_val_q, stg_val_d;
    logic [3:0]       stg_dp_q, stg_dp_d;
    logic             pend_q, pend_d;
    logic [3:0]       bcd_q, bcd_d;
    logic [3:0]       digit_q, digit_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_done_q, frame_done_d;

    logic             slot_end;
    logic             frame_wrap;
    logic [3:0]       blank;
    logic             lit;

    // Scan position, double-buffered display data and frame strobe.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        stg_val_d    = stg_val_q;
        stg_dp_d     = stg_dp_q;
        pend_d       = pend_q;
        frame_done_d = 1'b0;
        slot_end     = (cnt_q == CNT_MAX);
        frame_wrap   = slot_end && (idx_q == 2'd3);

        if (en) begin
            cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
            idx_d        = slot_end ? idx_q + 2'd1 : idx_q;
            frame_done_d = frame_wrap;
            if (frame_wrap) begin
                // A load landing exactly on the wrap bypasses staging.
                if (load) begin
                    act_val_d = value;
                    act_dp_d  = dp_en;
                end else if (pend_q) begin
                    act_val_d = stg_val_q;
                    act_dp_d  = stg_dp_q;
                end
                pend_d = 1'b0;
            end else if (load) begin
                stg_val_d = value;
                stg_dp_d  = dp_en;
                pend_d    = 1'b1;
            end
        end else begin
            // Display is dark: no tearing possible, so write straight through.
            cnt_d  = '0;
            idx_d  = 2'd0;
            pend_d = 1'b0;
            if (load) begin
                act_val_d = value;
                act_dp_d  = dp_en;
            end else if (pend_q) begin
                act_val_d = stg_val_q;
                act_dp_d  = stg_dp_q;
            end
        end
    end

    // Digit drive derived from the current scan position and active data.
    always_comb begin
        blank[0] = 1'b0;
        blank[3] = lzb && (act_val_q[15:12] == 4'h0);
        blank[2] = blank[3] && (act_val_q[11:8] == 4'h0);
        blank[1] = blank[2] && (act_val_q[7:4] == 4'h0);

        lit     = en && ({1'b0, cnt_q} >= BLANK_V) && !blank[idx_q];
        bcd_d   = act_val_q[4*idx_q +: 4];
        digit_d = lit ? ~(4'b0001 << idx_q) : 4'b1111;
        dp_n_d  = !(lit && act_dp_q[idx_q]);
    end

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            act_val_q    <= 16'h0000;
            act_dp_q     <= 4'h0;
            stg_val_q    <= 16'h0000;
            stg_dp_q     <= 4'h0;
            pend_q       <= 1'b0;
            bcd_q        <= 4'h0;
            digit_q      <= 4'b1111;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            stg_val_q    <= stg_val_d;
            stg_dp_q     <= stg_dp_d;
            pend_q       <= pend_d;
            bcd_q        <= bcd_d;
            digit_q      <= digit_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bcd        = bcd_q;
    assign digit      = digit_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with DIV=4, BLANK=1.
// A table of per-cycle stimulus records with expected outputs is built first,
// then applied; expectations are queued at drive time and checked after the edge.
module tb_seven_seg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLANK = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_en = 4'h0;
    logic        lzb = 1'b0;
    logic [3:0]  bcd;
    logic [3:0]  digit;
    logic        dp_n;
    logic        frame_done;

    typedef struct {
        logic        rst;
        logic        en;
        logic        load;
        logic [15:0] value;
        logic [3:0]  dp;
        logic        lzb;
        logic [3:0]  ebcd;
        logic [3:0]  edig;
        logic        edpn;
        logic        efd;
    } vec_t;

    vec_t vecs[$];
    vec_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    seven_seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp_en      (dp_en),
        .lzb        (lzb),
        .bcd        (bcd),
        .digit      (digit),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Leading-zero blanking rule: digit k>0 is dark if it and every higher nibble is zero.
    function automatic logic blanked(input logic [15:0] v, input logic z, input int k);
        logic [15:0] t;
        t = v;
        if (!z || k == 0) return 1'b0;
        for (int j = k; j < 4; j++)
            if (t[4*j +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add(input logic r, input logic e, input logic l, input logic [15:0] v,
                       input logic [3:0] d, input logic z, input logic [3:0] eb,
                       input logic [3:0] ed, input logic ep, input logic ef);
        vec_t t;
        t.rst = r; t.en = e; t.load = l; t.value = v; t.dp = d; t.lzb = z;
        t.ebcd = eb; t.edig = ed; t.edpn = ep; t.efd = ef;
        vecs.push_back(t);
    endtask

    // n scanning cycles starting at digit 0, slot start, with the given active data.
    task automatic add_scan(input logic [15:0] av, input logic [3:0] ad, input logic z, input int n);
        logic [15:0] tv;
        logic [3:0]  td;
        logic [3:0]  ed;
        logic        on;
        tv = av;
        td = ad;
        for (int s = 0; s < n; s++) begin
            int k;
            int p;
            k  = s / 4;
            p  = s % 4;
            on = (p >= BLANK) && !blanked(av, z, k);
            ed = 4'b1111;
            if (on) ed[k] = 1'b0;
            add(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, z, tv[4*k +: 4], ed,
                !(on && td[k]), (k == 3 && p == 3));
        end
    endtask

    task automatic patch_load(input int i, input logic [15:0] v, input logic [3:0] d);
        vec_t t;
        t = vecs[i];
        t.load = 1'b1;
        t.value = v;
        t.dp = d;
        vecs[i] = t;
    endtask

    initial begin
        int base;
        vec_t e;

        // Reset has priority over en/load.
        add(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b0, 4'h0, 4'b1111, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'b1111, 1'b1, 1'b0);
        // Frame 0: value 0, all digits lit after the dead cycle.
        add_scan(16'h0000, 4'h0, 1'b0, 16);
        // Dark: direct load, then held.
        add(1'b0, 1'b0, 1'b1, 16'h1234, 4'b0010, 1'b0, 4'h0, 4'b1111, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'h4, 4'b1111, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'h4, 4'b1111, 1'b1, 1'b0);
        // Frame 1: 1234 with dp on digit 1; load 5678 during digit 1.
        base = vecs.size();
        add_scan(16'h1234, 4'b0010, 1'b0, 16);
        patch_load(base + 5, 16'h5678, 4'h0);
        // Frame 2: 5678; two loads, last wins.
        base = vecs.size();
        add_scan(16'h5678, 4'h0, 1'b0, 16);
        patch_load(base + 2, 16'h1111, 4'h0);
        patch_load(base + 9, 16'h2222, 4'h0);
        // Frame 3: 2222; load on the wrap cycle bypasses staging.
        base = vecs.size();
        add_scan(16'h2222, 4'h0, 1'b0, 16);
        patch_load(base + 15, 16'h3333, 4'h0);
        // Frame 4: 3333; stage 0040 with dp on digit 0.
        base = vecs.size();
        add_scan(16'h3333, 4'h0, 1'b0, 16);
        patch_load(base + 7, 16'h0040, 4'b0001);
        // Frame 5: leading-zero blanking of 0040.
        base = vecs.size();
        add_scan(16'h0040, 4'b0001, 1'b1, 16);
        patch_load(base + 11, 16'h0000, 4'h0);
        // Frame 6: all zero, only digit 0 lit.
        base = vecs.size();
        add_scan(16'h0000, 4'h0, 1'b1, 16);
        patch_load(base + 3, 16'h0A00, 4'h0);
        // Frame 7 (partial): hex nibble counts as non-zero; stage 9999 then reset mid-slot.
        base = vecs.size();
        add_scan(16'h0A00, 4'h0, 1'b1, 7);
        patch_load(base + 5, 16'h9999, 4'hF);
        add(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'b1111, 1'b1, 1'b0);
        // Frames 8 and 9: pending value discarded, scan restarts at digit 0.
        add_scan(16'h0000, 4'h0, 1'b0, 16);
        add_scan(16'h0000, 4'h0, 1'b1, 16);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            en    = vecs[i].en;
            load  = vecs[i].load;
            value = vecs[i].value;
            dp_en = vecs[i].dp;
            lzb   = vecs[i].lzb;
            sbq.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            checks++;
            if (bcd !== e.ebcd) begin
                failures++;
                $display("FAIL bcd step %0d got=%h want=%h", i, bcd, e.ebcd);
            end
            checks++;
            if (digit !== e.edig) begin
                failures++;
                $display("FAIL digit step %0d got=%b want=%b", i, digit, e.edig);
            end
            checks++;
            if (dp_n !== e.edpn) begin
                failures++;
                $display("FAIL dp_n step %0d got=%b want=%b", i, dp_n, e.edpn);
            end
            checks++;
            if (frame_done !== e.efd) begin
                failures++;
                $display("FAIL frame_done step %0d got=%b want=%b", i, frame_done, e.efd);
            end
        end

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
